// File: rtl/fifo_rd_stream_adapter.sv
// fifo_rd_stream_adapter
//   Read-side adapter for an async FIFO. It pops words through r_inc/r_empty/r_data
//   and presents them as a valid/ready stream on m_*. A 2-entry skid buffer hides the
//   FIFO's one-cycle read latency, so a word can move every cycle while m_ready is high.
//
//   Optional feature: define RD_WORD_COUNT_EN to add the rd_count port, which counts
//   stream transfers modulo 2**CNT_WIDTH. Without the macro the port and counter are absent.
//
//   Reset is asynchronous assert; release must be synchronised to r_clk by the
//   surrounding reset logic.

module fifo_rd_stream_adapter #(
    parameter int DATA_WIDTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  r_clk,
    input  logic                  r_reset,
    input  logic                  r_empty,
    input  logic [DATA_WIDTH-1:0] r_data,
    output logic                  r_inc,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready
`ifdef RD_WORD_COUNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  rd_count
`endif
);

    // Elaboration-time sanity check on the configuration.
    if (DATA_WIDTH < 1 || CNT_WIDTH < 1) begin : g_bad_params
        $error("fifo_rd_stream_adapter: DATA_WIDTH and CNT_WIDTH must be >= 1");
    end

    // Skid buffer occupancy; the encoding doubles as the word count.
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_t;

    buf_state_t            state;
    buf_state_t            state_nxt;
    logic                  inflight;
    logic [DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0] tail;
    logic [DATA_WIDTH-1:0] head_nxt;
    logic [DATA_WIDTH-1:0] tail_nxt;
    logic                  xfer;
    logic                  cap;
    logic [1:0]            occ_cnt;
    logic [2:0]            pending;

    // State register: buffer occupancy and the pop-issued-last-cycle flag.
    always_ff @(posedge r_clk or posedge r_reset) begin
        if (r_reset) begin
            state    <= BUF_EMPTY;
            inflight <= 1'b0;
        end else begin
            state    <= state_nxt;
            inflight <= r_inc;
        end
    end

    // Output logic: stream handshake and the FIFO pop request.
    always_comb begin
        case (state)
            BUF_EMPTY: occ_cnt = 2'd0;
            BUF_ONE:   occ_cnt = 2'd1;
            BUF_FULL:  occ_cnt = 2'd2;
            default:   occ_cnt = 2'd0;
        endcase
        m_valid = (state != BUF_EMPTY);
        m_data  = head;
        xfer    = m_valid && m_ready;
        cap     = inflight;
        // Words that will still be owed a slot after this edge's transfer.
        // A pop is only issued if that leaves room for the new word.
        pending = {1'b0, occ_cnt} + {2'b00, inflight} - {2'b00, xfer};
        r_inc   = !r_reset && !r_empty && (pending < 3'd2);
    end

    // Next-state logic: transfer retires the head, capture adds a word.
    always_comb begin
        state_nxt = state;
        case (state)
            BUF_EMPTY: begin
                if (cap) state_nxt = BUF_ONE;
            end
            BUF_ONE: begin
                if (cap && !xfer)      state_nxt = BUF_FULL;
                else if (!cap && xfer) state_nxt = BUF_EMPTY;
            end
            BUF_FULL: begin
                if (xfer && !cap) state_nxt = BUF_ONE;
            end
            default: state_nxt = BUF_EMPTY;
        endcase
    end

    // Slot update: a transfer shifts tail into head; the captured word lands in
    // whichever slot is the first free one after that shift, preserving order.
    always_comb begin
        head_nxt = head;
        tail_nxt = tail;
        if (xfer) begin
            head_nxt = tail;
        end
        if (cap) begin
            if ((state == BUF_EMPTY) || (state == BUF_ONE && xfer)) begin
                head_nxt = r_data;
            end else begin
                tail_nxt = r_data;
            end
        end
    end

    // Slot registers.
    always_ff @(posedge r_clk or posedge r_reset) begin
        if (r_reset) begin
            head <= '0;
            tail <= '0;
        end else begin
            head <= head_nxt;
            tail <= tail_nxt;
        end
    end

`ifdef RD_WORD_COUNT_EN
    // Transfer counter, wraps naturally at 2**CNT_WIDTH.
    always_ff @(posedge r_clk or posedge r_reset) begin
        if (r_reset) begin
            rd_count <= '0;
        end else if (xfer) begin
            rd_count <= rd_count + CNT_WIDTH'(1);
        end
    end
`else
    // Transfer counting disabled: no rd_count port and no counter state.
`endif

    // A capture into a full buffer with no transfer would drop a word.
    a_no_overflow : assert property (
        @(posedge r_clk) disable iff (r_reset)
        !(state == BUF_FULL && cap && !xfer)
    );

    // A presented word is held until the consumer takes it.
    a_valid_stable : assert property (
        @(posedge r_clk) disable iff (r_reset)
        (m_valid && !m_ready) |=> (m_valid && $stable(m_data))
    );

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// tb_fifo_rd_stream_adapter
//   Table of per-cycle vectors from reset, then FIFO-driven sequences (stream,
//   backpressure, alternating ready, reset mid-burst, random) checked against a
//   word-level reference model: a FIFO queue, a queue of popped-but-undelivered
//   words, and the pop rule expressed as counts.

module tb_fifo_rd_stream_adapter;

    localparam int DW = 4;
    localparam int CW = 4;

    logic          r_clk = 1'b0;
    logic          r_reset;
    logic          r_empty;
    logic [DW-1:0] r_data;
    logic          r_inc;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
`ifdef RD_WORD_COUNT_EN
    logic [CW-1:0] rd_count;
`endif

    always #5 r_clk = ~r_clk;

    fifo_rd_stream_adapter #(
        .DATA_WIDTH(DW),
        .CNT_WIDTH (CW)
    ) dut (
        .r_clk   (r_clk),
        .r_reset (r_reset),
        .r_empty (r_empty),
        .r_data  (r_data),
        .r_inc   (r_inc),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_ready (m_ready)
`ifdef RD_WORD_COUNT_EN
        ,
        .rd_count(rd_count)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Reference model state.
    logic [DW-1:0] fifo_q[$];   // words still inside the FIFO
    logic [DW-1:0] sb[$];       // popped, not yet delivered (oldest first)
    logic [DW-1:0] dlv_w[$];    // delivered words
    int            dlv_c[$];    // cycle index of each delivery
    int            infl_m = 0;  // 1 if the newest entry of sb was popped last edge
    int            cnt_m  = 0;  // transfers since reset
    int            cyc    = 0;
    int            inc_cnt = 0;

    typedef struct packed {
        logic          rst;
        logic          empty;
        logic          rdy;
        logic [DW-1:0] data;
        logic          inc;
        logic          valid;
        logic [DW-1:0] mdata;
    } vec_t;

    vec_t tbl[21];

    function automatic vec_t mk(input logic rst, input logic empty, input logic rdy,
                                input logic [DW-1:0] data, input logic inc,
                                input logic valid, input logic [DW-1:0] mdata);
        vec_t v;
        v.rst = rst; v.empty = empty; v.rdy = rdy; v.data = data;
        v.inc = inc; v.valid = valid; v.mdata = mdata;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One clock cycle driven from the FIFO model; outputs checked against the model.
    task automatic cycle(input bit rst, input bit hold, input bit rdy);
        bit            exp_valid;
        bit            exp_inc;
        bit            do_pop;
        bit            do_xfer;
        int            occ_m;
        logic [DW-1:0] w;
        r_reset = rst;
        r_empty = hold || (fifo_q.size() == 0);
        m_ready = rdy;
        if (rst) begin
            sb.delete();
            infl_m = 0;
            cnt_m  = 0;
        end
        #1;
        occ_m     = sb.size() - infl_m;
        exp_valid = (occ_m > 0);
        exp_inc   = !rst && !r_empty && ((sb.size() - ((exp_valid && rdy) ? 1 : 0)) < 2);
        chk("r_inc", 32'(r_inc), 32'(exp_inc));
        chk("m_valid", 32'(m_valid), 32'(exp_valid));
        if (exp_valid) chk("m_data", 32'(m_data), 32'(sb[0]));
        else if (rst)  chk("m_data_rst", 32'(m_data), 32'd0);
        chk("words_owed_le_2", 32'(sb.size() <= 2), 32'd1);
`ifdef RD_WORD_COUNT_EN
        chk("rd_count", 32'(rd_count), 32'(cnt_m % (1 << CW)));
`endif
        do_pop  = r_inc && !r_empty;
        do_xfer = m_valid && m_ready;
        if (r_inc) inc_cnt++;
        if (do_xfer) begin
            dlv_w.push_back(m_data);
            dlv_c.push_back(cyc);
        end
        @(posedge r_clk);
        #1;
        cyc++;
        if (do_xfer) begin
            if (sb.size() > 0) void'(sb.pop_front());
            cnt_m++;
        end
        if (do_pop) begin
            w = fifo_q.pop_front();
            sb.push_back(w);
            r_data = w;
            infl_m = 1;
        end else begin
            r_data = DW'($urandom);
            infl_m = 0;
        end
    endtask

    task automatic run(input int n, input bit hold, input bit rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, hold, rdy);
    endtask

    task automatic fill(input int lo, input int n);
        for (int i = 0; i < n; i++) fifo_q.push_back(DW'(lo + i));
    endtask

    task automatic clear_logs();
        dlv_w.delete();
        dlv_c.delete();
        inc_cnt = 0;
    endtask

    task automatic do_reset();
        fifo_q.delete();
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        clear_logs();
    endtask

    initial begin
        int start;

        // rst, empty, rdy, r_data  ->  r_inc, m_valid, m_data (m_data checked when valid or rst)
        tbl[0]  = mk(1, 0, 1, 4'd0, 0, 0, 4'd0);
        tbl[1]  = mk(0, 0, 0, 4'd0, 1, 0, 4'd0);
        tbl[2]  = mk(0, 0, 0, 4'd1, 1, 0, 4'd0);
        tbl[3]  = mk(0, 0, 0, 4'd2, 0, 1, 4'd1);
        tbl[4]  = mk(0, 0, 0, 4'd9, 0, 1, 4'd1);
        tbl[5]  = mk(0, 0, 1, 4'd9, 1, 1, 4'd1);
        tbl[6]  = mk(0, 0, 1, 4'd3, 1, 1, 4'd2);
        tbl[7]  = mk(0, 1, 1, 4'd4, 0, 1, 4'd3);
        tbl[8]  = mk(0, 1, 0, 4'd9, 0, 1, 4'd4);
        tbl[9]  = mk(0, 1, 1, 4'd9, 0, 1, 4'd4);
        tbl[10] = mk(0, 1, 1, 4'd9, 0, 0, 4'd0);
        tbl[11] = mk(0, 0, 1, 4'd9, 1, 0, 4'd0);
        tbl[12] = mk(0, 0, 1, 4'd7, 1, 0, 4'd0);
        tbl[13] = mk(0, 1, 1, 4'd8, 0, 1, 4'd7);
        tbl[14] = mk(0, 1, 1, 4'd9, 0, 1, 4'd8);
        tbl[15] = mk(0, 1, 1, 4'd9, 0, 0, 4'd0);
        tbl[16] = mk(0, 0, 0, 4'd9, 1, 0, 4'd0);
        tbl[17] = mk(0, 0, 0, 4'd5, 1, 0, 4'd0);
        tbl[18] = mk(0, 0, 0, 4'd6, 0, 1, 4'd5);
        tbl[19] = mk(1, 0, 0, 4'd9, 0, 0, 4'd0);
        tbl[20] = mk(0, 0, 1, 4'd9, 1, 0, 4'd0);

        r_reset = 1'b1;
        r_empty = 1'b0;
        m_ready = 1'b0;
        r_data  = '0;
        @(posedge r_clk); #1;
        @(posedge r_clk); #1;

        for (int i = 0; i < 21; i++) begin
            r_reset = tbl[i].rst;
            r_empty = tbl[i].empty;
            m_ready = tbl[i].rdy;
            r_data  = tbl[i].data;
            #1;
            chk($sformatf("vec%0d_r_inc", i), 32'(r_inc), 32'(tbl[i].inc));
            chk($sformatf("vec%0d_m_valid", i), 32'(m_valid), 32'(tbl[i].valid));
            if (tbl[i].valid || tbl[i].rst)
                chk($sformatf("vec%0d_m_data", i), 32'(m_data), 32'(tbl[i].mdata));
            @(posedge r_clk); #1;
        end

        // Stream: 8 words, ready held high.
        do_reset();
        fill(1, 8);
        start = cyc;
        run(12, 1'b0, 1'b1);
        chk("stream_count", 32'(dlv_w.size()), 32'd8);
        chk("stream_pops", 32'(inc_cnt), 32'd8);
        for (int i = 0; i < dlv_w.size(); i++) begin
            chk("stream_word", 32'(dlv_w[i]), 32'(i + 1));
            chk("stream_cycle", 32'(dlv_c[i]), 32'(start + 2 + i));
        end

        // Backpressure: 5 words, ready low then high.
        do_reset();
        fill(1, 5);
        start = cyc;
        run(6, 1'b0, 1'b0);
        chk("bp_pops_stalled", 32'(inc_cnt), 32'd2);
        chk("bp_none_delivered", 32'(dlv_w.size()), 32'd0);
        run(8, 1'b0, 1'b1);
        chk("bp_count", 32'(dlv_w.size()), 32'd5);
        chk("bp_pops_total", 32'(inc_cnt), 32'd5);
        for (int i = 0; i < dlv_w.size(); i++) begin
            chk("bp_word", 32'(dlv_w[i]), 32'(i + 1));
            chk("bp_cycle", 32'(dlv_c[i]), 32'(start + 6 + i));
        end

        // Alternating ready, 16 words.
        do_reset();
        fill(0, 16);
        for (int i = 0; i < 48; i++) cycle(1'b0, 1'b0, (i % 2) == 0);
        chk("alt_count", 32'(dlv_w.size()), 32'd16);
        for (int i = 0; i < dlv_w.size(); i++) chk("alt_word", 32'(dlv_w[i]), 32'(i));

        // Reset mid-burst: one word buffered, one in flight, both discarded.
        do_reset();
        fill(10, 6);
        run(2, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        clear_logs();
        run(8, 1'b0, 1'b1);
        chk("rst_resume_count", 32'(dlv_w.size()), 32'd4);
        for (int i = 0; i < dlv_w.size(); i++) chk("rst_resume_word", 32'(dlv_w[i]), 32'(12 + i));

        // Random traffic with occasional resets, then drain.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) == 0 && fifo_q.size() < 8) fifo_q.push_back(DW'($urandom));
            cycle($urandom_range(0, 99) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 2) != 0);
        end
        run(20, 1'b0, 1'b1);
        chk("drain_fifo_empty", 32'(fifo_q.size()), 32'd0);
        chk("drain_buffer_empty", 32'(sb.size()), 32'd0);

`ifdef RD_WORD_COUNT_EN
        // 17 transfers on a 4-bit counter wrap to 1.
        do_reset();
        fill(0, 17);
        run(24, 1'b0, 1'b1);
        chk("wrap_transfers", 32'(dlv_w.size()), 32'd17);
        chk("wrap_rd_count", 32'(rd_count), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
